// File: rtl/blink_rate_ctrl.sv
// Button front end for the LED blinker: synchronise, debounce, pulse on press,
// step a 2-bit blink rate and run the matching half-period timebase.
module blink_rate_ctrl #(
   parameter int CLK_HZ       = 125000000,
   parameter int DEBOUNCE_CYC = 1250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   output logic       btn_level,
   output logic       btn_press,
   output logic [1:0] rate_sel,
   output logic       half_tick,
   output logic       phase,
   output logic [1:0] dbg_state
);

   localparam int DCW = $clog2(DEBOUNCE_CYC + 1);
   localparam int TCW = $clog2(CLK_HZ / 2);

   localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYC - 1);
   localparam logic [TCW-1:0] HALF_M1_R0 = TCW'(CLK_HZ / 2 - 1);
   localparam logic [TCW-1:0] HALF_M1_R1 = TCW'(CLK_HZ / 4 - 1);
   localparam logic [TCW-1:0] HALF_M1_R2 = TCW'(CLK_HZ / 8 - 1);
   localparam logic [TCW-1:0] HALF_M1_R3 = TCW'(CLK_HZ / 16 - 1);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } deb_state_t;

   deb_state_t     state_q, state_d;
   logic           s1_q, s1_d;
   logic           s2_q, s2_d;
   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic           level_q, level_d;
   logic           press_q, press_d;
   logic [1:0]     rate_q, rate_d;
   logic [TCW-1:0] tcnt_q, tcnt_d;
   logic [TCW-1:0] half_m1;
   logic           tick_q, tick_d;
   logic           phase_q, phase_d;

   // Valid/ready style handshakes do not apply here; btn_press is a strobe
   // that is valid for exactly one cycle and needs no acknowledgement.
   always_comb begin
      s1_d    = btn;
      s2_d    = s1_q;
      state_d = state_q;
      dcnt_d  = dcnt_q;
      level_d = level_q;
      press_d = 1'b0;
      case (state_q)
         IDLE_LO: begin
            if (s2_q) begin
               state_d = WAIT_HI;
               dcnt_d  = DCW'(1);
            end
         end
         WAIT_HI: begin
            if (!s2_q) begin
               state_d = IDLE_LO;
               dcnt_d  = '0;
            end else if (dcnt_q == DEB_LAST) begin
               state_d = IDLE_HI;
               dcnt_d  = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         IDLE_HI: begin
            if (!s2_q) begin
               state_d = WAIT_LO;
               dcnt_d  = DCW'(1);
            end
         end
         WAIT_LO: begin
            if (s2_q) begin
               state_d = IDLE_HI;
               dcnt_d  = '0;
            end else if (dcnt_q == DEB_LAST) begin
               state_d = IDLE_LO;
               dcnt_d  = '0;
               level_d = 1'b0;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE_LO;
            dcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      case (rate_q)
         2'd0:    half_m1 = HALF_M1_R0;
         2'd1:    half_m1 = HALF_M1_R1;
         2'd2:    half_m1 = HALF_M1_R2;
         default: half_m1 = HALF_M1_R3;
      endcase
   end

   // A rate change restarts the half-period and wins over a coincident terminal count.
   always_comb begin
      rate_d  = rate_q;
      tcnt_d  = tcnt_q + 1'b1;
      tick_d  = 1'b0;
      phase_d = phase_q;
      if (press_q) begin
         rate_d = rate_q + 2'd1;
         tcnt_d = '0;
      end else if (tcnt_q == half_m1) begin
         tcnt_d  = '0;
         tick_d  = 1'b1;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= IDLE_LO;
         dcnt_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rate_q  <= 2'd0;
         tcnt_q  <= '0;
         tick_q  <= 1'b0;
         phase_q <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rate_q  <= rate_d;
         tcnt_q  <= tcnt_d;
         tick_q  <= tick_d;
         phase_q <= phase_d;
      end
   end

   assign btn_level = level_q;
   assign btn_press = press_q;
   assign rate_sel  = rate_q;
   assign half_tick = tick_q;
   assign phase     = phase_q;
   assign dbg_state = state_q;

endmodule
